// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divide/remainder controller for the EX stage.
// Holds the pipeline via stall_req while iterating, then pulses done with a sign-corrected result.
module div_sequencer #(
    parameter int XLEN = 64
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic            is_rem,
    input  logic            is_signed,
    input  logic            word_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [2:0]      state_dbg
);
    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN + 1);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] a_q, b_q, rem_q, quot_q, result_q;
    logic            rem_op_q, signed_q, word_q, sign_q, sign_r;
    logic [CW-1:0]   cnt_q;

    // Operand preparation: active-width extension, magnitudes and special-case detection.
    logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, most_neg, a_sext, dz_res, ovf_res;
    logic            neg_a, neg_b, div_zero, overflow;
    logic [CW-1:0]   iter_n;

    always_comb begin
        a_sext = {{HALF{a_q[HALF-1]}}, a_q[HALF-1:0]};
        ext_a  = a_q;
        ext_b  = b_q;
        if (word_q) begin
            ext_a = signed_q ? a_sext : {{HALF{1'b0}}, a_q[HALF-1:0]};
            ext_b = signed_q ? {{HALF{b_q[HALF-1]}}, b_q[HALF-1:0]}
                             : {{HALF{1'b0}}, b_q[HALF-1:0]};
        end
        neg_a    = signed_q & ext_a[XLEN-1];
        neg_b    = signed_q & ext_b[XLEN-1];
        mag_a    = neg_a ? -ext_a : ext_a;
        mag_b    = neg_b ? -ext_b : ext_b;
        most_neg = word_q ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (ext_b == '0);
        overflow = signed_q & (ext_a == most_neg) & (ext_b == '1);
        dz_res   = rem_op_q ? (word_q ? a_sext : a_q) : '1;
        ovf_res  = rem_op_q ? '0 : most_neg;
        iter_n   = word_q ? CW'(HALF) : CW'(XLEN);
    end

    // One restoring step: bring the next dividend bit into rem and trial-subtract.
    logic [XLEN:0] shifted, diff;
    logic          borrow;

    always_comb begin
        shifted = {rem_q, quot_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        borrow  = diff[XLEN];
    end

    logic [XLEN-1:0] q_fix, r_fix, sel_fix, fix_res;

    always_comb begin
        q_fix   = sign_q ? -quot_q : quot_q;
        r_fix   = sign_r ? -rem_q : rem_q;
        sel_fix = rem_op_q ? r_fix : q_fix;
        fix_res = word_q ? {{HALF{sel_fix[HALF-1]}}, sel_fix[HALF-1:0]} : sel_fix;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = PREP;
                PREP:    state_nxt = (div_zero || overflow) ? DONE : CALC;
                CALC:    if (cnt_q == CW'(1)) state_nxt = FIX;
                FIX:     state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath registers; a flush in any state leaves everything, including result, untouched.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            result_q <= '0;
            rem_op_q <= 1'b0;
            signed_q <= 1'b0;
            word_q   <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            cnt_q    <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q      <= dividend;
                        b_q      <= divisor;
                        rem_op_q <= is_rem;
                        signed_q <= is_signed;
                        word_q   <= word_op;
                    end
                end
                PREP: begin
                    b_q    <= mag_b;
                    quot_q <= word_q ? {mag_a[HALF-1:0], {HALF{1'b0}}} : mag_a;
                    rem_q  <= '0;
                    sign_q <= neg_a ^ neg_b;
                    sign_r <= neg_a;
                    cnt_q  <= iter_n;
                    if (div_zero) begin
                        result_q <= dz_res;
                    end else if (overflow) begin
                        result_q <= ovf_res;
                    end
                end
                CALC: begin
                    rem_q  <= borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
                    quot_q <= {quot_q[XLEN-2:0], ~borrow};
                    cnt_q  <= cnt_q - CW'(1);
                end
                FIX: begin
                    result_q <= fix_res;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign stall_req = (start & (state == IDLE) & ~flush) | (state == PREP) |
                       (state == CALC) | (state == FIX);
    assign result    = result_q;
    assign state_dbg = state;

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller for the execute stage's divide/remainder operations (div, divu, rem, remu, and their word forms). It accepts one operation from the EX stage and runs a radix-2 restoring divider over 32 or 64 iterations. While the operation is in flight it holds the pipeline through a stall request, then presents a sign-corrected result for one cycle. The result is muxed into the ALU result path ahead of EX/MEM.

## Interface
- Parameters:
- XLEN, 64, datapath width; word ops use the low XLEN/2 bits.
- Ports:
- sys_clk  in  1  clock; all state updates on the rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request to begin an operation; sampled only in IDLE.
- flush  in  1  synchronous abort from branch/jump redirect.
- is_rem  in  1  1 = remainder, 0 = quotient.
- is_signed  in  1  1 = div/rem(w), 0 = divu/remu(w).
- word_op  in  1  32-bit operation with a sign-extended 64-bit result.
- dividend  in  XLEN  rs1 operand, sampled with start.
- divisor  in  XLEN  rs2 operand, sampled with start.
- busy  out  1  high when state != IDLE.
- stall_req  out  1  freezes IF/ID/EX; defined as (start & IDLE & ~flush) | CALC | PREP | FIX.
- done  out  1  single-cycle pulse; result is valid this cycle.
- result  out  XLEN  final value; holds its last value until the next done.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: on start & ~flush, latch operands and controls, then go to PREP. Start while busy is ignored.
- PREP:
  - Word op: take the low 32 bits, sign-extended if is_signed, otherwise zero-extended.
  - Record sign_q = sign(a) ^ sign(b) and sign_r = sign(a) (signed ops only).
  - Convert both operands to magnitudes.
  - Iteration count N = 32 for word ops, 64 otherwise.
  - If divisor == 0 or signed overflow is detected, go to DONE with the special result; otherwise go to CALC.
- CALC: each cycle, shift {rem, quot} left by 1. Trial-subtract the magnitude divisor from rem. If no borrow, keep the difference and set quot[0] = 1. The iteration counter decrements each cycle; after N cycles go to FIX.
- FIX:
  - Negate the quotient if sign_q; negate the remainder if sign_r.
  - Select the quotient or remainder per is_rem.
  - Word op: sign-extend result from bit 31, including the unsigned word forms.
  - Go to DONE.
- DONE: assert done and drive result; go to IDLE on the next edge. stall_req is low here so the pipeline advances and captures result.
- Divide-by-zero special result:
  - Quotient is all ones.
  - Remainder is the dividend; for word ops, the sign-extended low 32 bits.
- Signed-overflow special result (most-negative value / −1 at the active width):
  - Quotient is the most-negative value, sign-extended for word ops.
  - Remainder is 0.
- flush: from any state, return to IDLE on the next edge. done is not asserted and result is unchanged. flush has priority over start in the same cycle.

## Timing
- Reset (async, sys_rst_n low): state = IDLE, counter = 0, busy = 0, done = 0, result = 0, and all internal registers = 0. Reset mid-operation discards the operation.
- start high in cycle 0 (edge E0 latches). Normal operation: PREP in cycle 1, CALC in cycles 2..N+1, FIX in cycle N+2, DONE in cycle N+3.
  - done latency: 67 cycles for 64-bit, 35 cycles for word ops.
- Special cases: PREP in cycle 1, done in cycle 2.
- stall_req is high from cycle 0 through the cycle before DONE.
- The next operation can start in the cycle after DONE.
- Operands and controls are registered at E0; later changes on the inputs have no effect.

## Test plan
- divu, 64-bit: dividend 100, divisor 7, is_rem = 0 → done in cycle 67, result 14; stall_req high for cycles 0–66.
- rem, signed: dividend −7, divisor 2 → result −1 (0xFFFF_FFFF_FFFF_FFFF); with is_rem = 0 → result −3.
- divuw: dividend 0x0000_0001_FFFF_FFFE, divisor 1 → done in cycle 35, result 0xFFFF_FFFF_FFFF_FFFE.
- Special cases, each with done in cycle 2:
  - Divide by 0: div → all ones; rem → dividend 0x1234.
  - divw: 0x8000_0000 / −1 → 0xFFFF_FFFF_8000_0000; remw → 0.
- Abort and overlap:
  - flush in cycle 20 of a 64-bit op → IDLE in cycle 21, no done pulse, result unchanged.
  - start held high continuously → a second op starts only in the cycle after DONE.
- Reset mid-CALC: sys_rst_n low asynchronously → busy, done, and result are 0 immediately. After release, a new op completes normally.
